// File: rtl/pht_bank_if.sv
// Lookup/update/history bundle for pht_bank; master is the predictor side,
// slave is the table.
interface pht_bank_if #(
  parameter int unsigned INDEX_W = 6
);
  logic               lookup_vld;
  logic [INDEX_W-1:0] pc_idx;
  logic               rd_vld;
  logic [1:0]         rd_data;
  logic [INDEX_W-1:0] rd_idx;
  logic               pred_taken;
  logic               upd_vld;
  logic [INDEX_W-1:0] upd_idx;
  logic [1:0]         upd_data;
  logic               hist_vld;
  logic               hist_taken;
  logic               busy;

  modport master (
    output lookup_vld, pc_idx, upd_vld, upd_idx, upd_data, hist_vld, hist_taken,
    input  rd_vld, rd_data, rd_idx, pred_taken, busy
  );

  modport slave (
    input  lookup_vld, pc_idx, upd_vld, upd_idx, upd_data, hist_vld, hist_taken,
    output rd_vld, rd_data, rd_idx, pred_taken, busy
  );
endinterface

// File: rtl/pht_bank.sv
// Pattern history table of 2-bit counters with a reset-time init sweep.
// Define PHT_GSHARE_EN to hash the lookup index with a global history register.
module pht_bank #(
  parameter int unsigned INDEX_W    = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input logic        clk,
  input logic        reset,
  pht_bank_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << INDEX_W;

  typedef enum logic {SWEEP, RUN} state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] sweep_ptr_q, sweep_ptr_d;
  logic               rd_vld_q, rd_vld_d;
  logic [1:0]         rd_data_q, rd_data_d;
  logic [INDEX_W-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]         table_q [DEPTH];

  logic               wr_en;
  logic [INDEX_W-1:0] wr_idx;
  logic [1:0]         wr_data;
  logic [INDEX_W-1:0] eff_idx;

`ifdef PHT_GSHARE_EN
  logic [INDEX_W-1:0] ghr_q, ghr_d;

  // Lookups use the pre-shift history; the shifted-out MSB is dropped.
  always_comb begin
    ghr_d = ghr_q;
    if (state_q == RUN && bus.hist_vld)
      ghr_d = {ghr_q[INDEX_W-2:0], bus.hist_taken};
  end

  always_ff @(posedge clk) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign eff_idx = bus.pc_idx ^ ghr_q;
`else
  assign eff_idx = bus.pc_idx;
`endif

  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    rd_vld_d    = 1'b0;
    rd_data_d   = rd_data_q;
    rd_idx_d    = rd_idx_q;
    wr_en       = 1'b0;
    wr_idx      = sweep_ptr_q;
    wr_data     = INIT_STATE;
    case (state_q)
      SWEEP: begin
        wr_en = 1'b1;
        if (sweep_ptr_q == '1) state_d     = RUN;
        else                   sweep_ptr_d = sweep_ptr_q + 1'b1;
      end
      RUN: begin
        wr_en   = bus.upd_vld;
        wr_idx  = bus.upd_idx;
        wr_data = bus.upd_data;
        if (bus.lookup_vld) begin
          rd_vld_d = 1'b1;
          rd_idx_d = eff_idx;
          // Write-first: a same-cycle update to the looked-up entry wins.
          if (bus.upd_vld && bus.upd_idx == eff_idx) rd_data_d = bus.upd_data;
          else                                       rd_data_d = table_q[eff_idx];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SWEEP;
      sweep_ptr_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= INIT_STATE;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      rd_vld_q    <= rd_vld_d;
      rd_data_q   <= rd_data_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  // Table contents are left untouched while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) table_q[wr_idx] <= wr_data;
  end

  assign bus.rd_vld     = rd_vld_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_idx     = rd_idx_q;
  assign bus.pred_taken = rd_data_q[1];
  assign bus.busy       = (state_q == SWEEP);

endmodule

// File: doc/pht_bank.md
PHT_BANK -- requirements
Module: pht_bank

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, giving the entry index width; the table holds 2^INDEX_W entries.
REQ-002 SHALL have parameter INIT_STATE, default 2'b01, giving the counter value loaded into every entry after reset.
REQ-003 SHALL have port clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port lookup_vld  input  1  lookup request.
REQ-006 SHALL have port pc_idx  input  INDEX_W  branch PC index bits.
REQ-007 SHALL have port rd_vld  output  1  rd_data valid.
REQ-008 SHALL have port rd_data  output  2  2-bit counter fed to the downstream predictor FSM in_data.
REQ-009 SHALL have port rd_idx  output  INDEX_W  table index used for the returned lookup; the caller carries it to the update.
REQ-010 SHALL have port pred_taken  output  1  rd_data[1].
REQ-011 SHALL have port upd_vld  input  1  write-back strobe, driven by the FSM wr_en.
REQ-012 SHALL have port upd_idx  input  INDEX_W  write-back index.
REQ-013 SHALL have port upd_data  input  2  write-back counter, driven by the FSM out_data.
REQ-014 SHALL have port hist_vld  input  1  branch resolved.
REQ-015 SHALL have port hist_taken  input  1  resolved outcome.
REQ-016 SHALL have port busy  output  1  initialisation sweep in progress.

Function
REQ-017 SHALL use counter encoding 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
REQ-018 SHALL implement a two-state controller: SWEEP and RUN.
REQ-019 SHALL, in SWEEP, write INIT_STATE to entry sweep_ptr each cycle, starting at 0 and incrementing by 1.
REQ-020 SHALL move from SWEEP to RUN on the cycle after sweep_ptr = 2^INDEX_W-1 is written, with busy = 1 throughout SWEEP and 0 in RUN.
REQ-021 SHALL, in SWEEP, ignore lookup_vld, upd_vld and hist_vld, and hold rd_vld = 0.
REQ-022 SHALL, in RUN, give lookup latency 1: lookup_vld at edge N sets rd_vld = 1 and presents rd_data and rd_idx after edge N, held until the next edge.
REQ-023 SHALL drive rd_vld = 0 in any cycle following a cycle without lookup_vld.
REQ-024 SHALL hold the last rd_data and rd_idx values while rd_vld = 0.
REQ-025 SHALL, in RUN, write upd_data to entry upd_idx at the edge where upd_vld = 1.
REQ-026 SHALL, for a lookup and an update in the same cycle at the same effective index, return upd_data as rd_data (write-first bypass).
REQ-027 SHALL, for a lookup and an update in the same cycle at different indices, perform both independently.
REQ-028 SHALL hold an INDEX_W-bit global history register GHR that, on hist_vld in RUN, takes the value {GHR[INDEX_W-2:0], hist_taken}.
REQ-029 SHALL, for a lookup coincident with hist_vld, use the GHR value before the shift.
REQ-030 SHALL discard the carried-out GHR MSB (wrap-around is discard).

Reset
REQ-031 SHALL, on reset, enter SWEEP with sweep_ptr = 0, busy = 1, rd_vld = 0, rd_data = INIT_STATE, rd_idx = 0, pred_taken = INIT_STATE[1] and GHR = 0.
REQ-032 SHALL make reset override all other inputs in the same cycle.
REQ-033 SHALL, on reset asserted mid-sweep or mid-operation, restart the sweep from entry 0.
REQ-034 SHALL not touch table contents while reset is held.

Configuration
REQ-035 SHALL use macro PHT_GSHARE_EN to select the lookup indexing scheme.
REQ-036 SHALL, with PHT_GSHARE_EN defined, use effective lookup index = pc_idx XOR GHR.
REQ-037 SHALL, with PHT_GSHARE_EN undefined, use effective lookup index = pc_idx (bimodal), leaving GHR and its logic absent and hist_vld/hist_taken unused.
REQ-038 SHALL, in both configurations, use upd_idx directly with no hashing.

Verification (INDEX_W=4, INIT_STATE=01)
REQ-039 Reset 1 cycle -> busy=1 for exactly 16 cycles, then busy=0; lookup of every index 0..15 returns 01, pred_taken=0.
REQ-040 RUN: upd_vld idx 5 data 11, next cycle lookup pc_idx 5 (GHR=0) -> rd_vld=1, rd_data=11, pred_taken=1, rd_idx=5.
REQ-041 Same cycle lookup pc_idx 7 and upd_vld idx 7 data 10 -> rd_data=10 the next cycle.
REQ-042 PHT_GSHARE_EN: hist_vld with taken=1,1,0,1 -> GHR=1101; lookup pc_idx 0010 -> rd_idx=1111; without the macro -> rd_idx=0010.
REQ-043 Reset asserted at sweep cycle 8, then released -> sweep restarts at 0, busy lasts 16 more cycles, and a lookup issued during busy yields rd_vld=0.
REQ-044 Lookup pulses in back-to-back cycles at idx 1,2,3 -> rd_vld=1 for 3 consecutive cycles with matching rd_idx, then 0.
